exec_seq: RTL

EXEC_SEQ -- requirements
Module: exec_seq

---
 rtl/exec_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_seq.sv
// ---------------------------------------------------------------------------
// exec_seq : Y86-64 execute stage sequencer driving a shared external ALU.
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module exec_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [N-1:0] valA,
  input  logic [N-1:0] valB,
  input  logic [N-1:0] valC,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_fn,
  input  logic [N-1:0] alu_out,
  input  logic [2:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] valE,
  output logic         cnd,
  output logic         err,
  output logic [2:0]   cc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [1:0]   FN_ADD     = 2'b00;
  localparam logic [1:0]   FN_SUB     = 2'b01;
  localparam logic [N-1:0] STACK_STEP = N'(8);
  localparam logic [2:0]   CC_RESET   = 3'b100;

  state_t       state_q, state_d;
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q,  ifun_d;
  logic [N-1:0] vala_q,  vala_d;
  logic [N-1:0] valb_q,  valb_d;
  logic [N-1:0] valc_q,  valc_d;
  logic [N-1:0] vale_q,  vale_d;
  logic         cnd_q,   cnd_d;
  logic         err_q,   err_d;
  logic [2:0]   cc_q,    cc_d;

  logic         is_err;
  logic         is_cond;
  logic         zero_result;

  // Condition decode over {ZF,SF,OF}.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, sf, of;
    zf = flags[2];
    sf = flags[1];
    of = flags[0];
    case (fn)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = (sf ^ of) | zf;
      4'h2:    cond_eval = sf ^ of;
      4'h3:    cond_eval = zf;
      4'h4:    cond_eval = ~zf;
      4'h5:    cond_eval = ~(sf ^ of);
      4'h6:    cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    is_err      = (icode_q >= 4'hC);
    is_cond     = (icode_q == ICODE_RRMOVQ) || (icode_q == ICODE_JXX);
    zero_result = is_err || (icode_q == ICODE_HALT) || (icode_q == ICODE_NOP);
  end

  // The ALU is only driven while executing; it stays at zero otherwise.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = FN_ADD;
    if (state_q == S_EXEC) begin
      case (icode_q)
        ICODE_OPQ: begin
          alu_a  = valb_q;
          alu_b  = vala_q;
          alu_fn = ifun_q[1:0];
        end
        ICODE_RMMOVQ, ICODE_MRMOVQ: begin
          alu_a = valc_q;
          alu_b = valb_q;
        end
        ICODE_IRMOVQ: alu_b = valc_q;
        ICODE_RRMOVQ: alu_b = vala_q;
        ICODE_CALL, ICODE_PUSHQ: begin
          alu_a  = valb_q;
          alu_b  = STACK_STEP;
          alu_fn = FN_SUB;
        end
        ICODE_RET, ICODE_POPQ: begin
          alu_a = valb_q;
          alu_b = STACK_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    valc_d  = valc_q;
    vale_d  = vale_q;
    cnd_d   = cnd_q;
    err_d   = err_q;
    cc_d    = cc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          icode_d = icode;
          ifun_d  = ifun;
          vala_d  = valA;
          valb_d  = valB;
          valc_d  = valC;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        vale_d  = zero_result ? '0 : alu_out;
        // Conditions use the flags as they stood before this instruction.
        cnd_d   = is_cond && cond_eval(ifun_q, cc_q);
        err_d   = is_err;
        if (icode_q == ICODE_OPQ) begin
          cc_d = alu_flags;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      icode_q <= '0;
      ifun_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      valc_q  <= '0;
      vale_q  <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= CC_RESET;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      valc_q  <= valc_d;
      vale_q  <= vale_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    valE      = vale_q;
    cnd       = cnd_q;
    err       = err_q;
    cc        = cc_q;
  end

endmodule

`default_nettype wire
